// File: rtl/pwm_ramp_scheduler.sv
// pwm_ramp_scheduler
// Holds a target duty per PWM channel and ramps each channel's live compare
// value toward it in fixed steps. Channels share one compare/write bus through
// a round-robin sweep that is started by a programmable tick.
module pwm_ramp_scheduler #(
    parameter int                CH       = 8,
    parameter int                DATA_W   = 8,
    parameter logic [DATA_W-1:0] STEP_RST = DATA_W'(1),
    parameter logic [15:0]       TICK_RST = 16'd999
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    input  logic [3:0]        cmd_addr,
    input  logic [DATA_W-1:0] cmd_data,
    output logic [CH-1:0]     pwm_wr,
    output logic [DATA_W-1:0] pwm_compare,
    output logic              busy,
    output logic [CH-1:0]     at_target
);

    localparam int               IDX_W    = (CH > 1) ? $clog2(CH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CH - 1);
    localparam logic [3:0]       ADDR_STEP   = 4'hC;
    localparam logic [3:0]       ADDR_PER_LO = 4'hD;
    localparam logic [3:0]       ADDR_PER_HI = 4'hE;

    typedef enum logic {IDLE, SCAN} state_t;

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              pending_q, pending_d;
    logic [15:0]       tick_cnt_q, tick_cnt_d;
    logic [15:0]       period_q, period_d;
    logic [DATA_W-1:0] step_q, step_d;
    logic [DATA_W-1:0] target_q  [CH];
    logic [DATA_W-1:0] target_d  [CH];
    logic [DATA_W-1:0] current_q [CH];
    logic [DATA_W-1:0] current_d [CH];
    logic [CH-1:0]     pwm_wr_q, pwm_wr_d;
    logic [DATA_W-1:0] pwm_compare_q, pwm_compare_d;

    logic              period_wr;
    logic              tick;
    logic [DATA_W-1:0] cur;
    logic [DATA_W-1:0] tgt;
    logic [DATA_W-1:0] nxt;

    // Command decode: channel targets, step and the two period bytes.
    always_comb begin
        // NOTE: every combinational output gets a default before any branch, so no path leaves it unassigned and no latch is inferred.
        step_d    = step_q;
        period_d  = period_q;
        target_d  = target_q;
        period_wr = 1'b0;
        if (cmd_valid) begin
            if (int'(cmd_addr) < CH) begin
                target_d[cmd_addr[IDX_W-1:0]] = cmd_data;
            end else begin
                case (cmd_addr)
                    ADDR_STEP: step_d = cmd_data;
                    ADDR_PER_LO: begin
                        period_d[7:0] = cmd_data[7:0];
                        period_wr     = 1'b1;
                    end
                    ADDR_PER_HI: begin
                        period_d[15:8] = cmd_data[7:0];
                        period_wr      = 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Tick generator: counts 0..period, ticks on the wrap; a period write restarts it.
    always_comb begin
        tick       = (tick_cnt_q == period_q);
        tick_cnt_d = (tick || period_wr) ? 16'd0 : tick_cnt_q + 16'd1;
    end

    // Next compare value for the channel in the current sweep slot.
    // Differences are only taken in the direction of travel, so nothing wraps.
    always_comb begin
        cur = current_q[idx_q];
        tgt = target_q[idx_q];
        nxt = tgt;
        if (step_q != '0) begin
            if (tgt > cur) begin
                nxt = (tgt - cur <= step_q) ? tgt : cur + step_q;
            end else begin
                nxt = (cur - tgt <= step_q) ? tgt : cur - step_q;
            end
        end
    end

    // Sweep FSM: starts on tick or a pending tick, visits one channel per cycle.
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        pending_d     = pending_q;
        current_d     = current_q;
        pwm_wr_d      = '0;
        pwm_compare_d = pwm_compare_q;
        case (state_q)
            IDLE: begin
                if (tick || pending_q) begin
                    state_d   = SCAN;
                    idx_d     = '0;
                    pending_d = 1'b0;
                end
            end
            SCAN: begin
                // Ticks seen mid-sweep collapse into one follow-up sweep.
                if (tick) begin
                    pending_d = 1'b1;
                end
                if (idx_q == LAST_IDX) begin
                    state_d = IDLE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
                if (cur != tgt) begin
                    current_d[idx_q] = nxt;
                    pwm_wr_d         = CH'(1) << idx_q;
                    pwm_compare_d    = nxt;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            idx_q         <= '0;
            pending_q     <= 1'b0;
            tick_cnt_q    <= 16'd0;
            period_q      <= TICK_RST;
            step_q        <= STEP_RST;
            pwm_wr_q      <= '0;
            pwm_compare_q <= '0;
            // NOTE: the per-channel arrays are reset on purpose: at_target must read all ones and no stale value may be ramped after reset.
            for (int i = 0; i < CH; i++) begin
                target_q[i]  <= '0;
                current_q[i] <= '0;
            end
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            pending_q     <= pending_d;
            tick_cnt_q    <= tick_cnt_d;
            period_q      <= period_d;
            step_q        <= step_d;
            pwm_wr_q      <= pwm_wr_d;
            pwm_compare_q <= pwm_compare_d;
            target_q      <= target_d;
            current_q     <= current_d;
        end
    end

    // Per-channel "settled" flags straight from the registers.
    always_comb begin
        for (int i = 0; i < CH; i++) begin
            at_target[i] = (current_q[i] == target_q[i]);
        end
    end

    assign pwm_wr      = pwm_wr_q;
    assign pwm_compare = pwm_compare_q;
    assign busy        = (state_q == SCAN);

endmodule
